// File: rtl/cmul_pkg.sv
// Shared types and constants for the complex-multiply sequencer.
// The product index selects which real product is issued or captured.
package cmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [1:0] idx_t;

    localparam idx_t P_RR = 2'd0;
    localparam idx_t P_II = 2'd1;
    localparam idx_t P_RI = 2'd2;
    localparam idx_t P_IR = 2'd3;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } tag_t;

endpackage

// File: rtl/cmul_tag_pipe.sv
// Delays the {valid, idx} tag of each issued product by MUL_LAT cycles so it
// lines up with the external multiplier's registered product.
module cmul_tag_pipe
    import cmul_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [MUL_LAT];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MUL_LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < MUL_LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[MUL_LAT-1];

endmodule

// File: rtl/cmul_sequencer.sv
// Sequences y = x * w through one shared external multiplier, four products in four cycles.
// Optional CMUL_CONJ_EN adds a conj input that computes x * conj(w) instead.
//   state | meaning
//   IDLE  | ready for operands
//   ISSUE | drive products RR, II, RI, IR to the multiplier
//   DRAIN | wait for the last product to return
//   DONE  | hold result until downstream takes it
module cmul_sequencer
    import cmul_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PROD    = 48,
    parameter int MUL_LAT = 1,
    parameter int OUT_W   = PROD + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_re,
    input  logic signed [WIDTH-1:0] x_im,
    input  logic signed [WIDTH/2-1:0] w_re,
    input  logic signed [WIDTH/2-1:0] w_im,
`ifdef CMUL_CONJ_EN
    input  logic                    conj,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y_re,
    output logic signed [OUT_W-1:0] y_im,
    output logic signed [WIDTH-1:0] mul_a,
    output logic signed [WIDTH/2-1:0] mul_b,
    input  logic signed [PROD-1:0]  mul_p
);

    state_t state_q, state_d;
    idx_t   idx_q, idx_d;
    logic   load;
    tag_t   tag_in, tag_out;

    logic signed [WIDTH-1:0]   xr_q, xi_q;
    logic signed [WIDTH/2-1:0] wr_q, wi_q;
    logic signed [OUT_W-1:0]   acc_re_q, acc_im_q;
    logic signed [OUT_W-1:0]   p_ext;
    logic                      conj_q;

    assign p_ext = OUT_W'(mul_p);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= P_RR;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        load       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        tag_in     = '0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted, even though the state already reads IDLE.
                in_ready = reset;
                if (in_valid) begin
                    load    = 1'b1;
                    idx_d   = P_RR;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_a        = (idx_q == P_RR || idx_q == P_RI) ? xr_q : xi_q;
                mul_b        = (idx_q == P_RR || idx_q == P_IR) ? wr_q : wi_q;
                tag_in.valid = 1'b1;
                tag_in.idx   = idx_q;
                idx_d        = idx_q + 2'd1;
                if (idx_q == P_IR) state_d = DRAIN;
            end
            DRAIN: begin
                if (tag_out.valid && tag_out.idx == P_IR) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    cmul_tag_pipe #(.MUL_LAT(MUL_LAT)) u_tag_pipe (
        .clock (clock),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

`ifdef CMUL_CONJ_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)    conj_q <= 1'b0;
        else if (load) conj_q <= conj;
    end
`else
    assign conj_q = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xr_q     <= '0;
            xi_q     <= '0;
            wr_q     <= '0;
            wi_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else if (load) begin
            xr_q     <= x_re;
            xi_q     <= x_im;
            wr_q     <= w_re;
            wi_q     <= w_im;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else if (tag_out.valid) begin
            // Conjugating w flips the sign of w_im, i.e. of the II and RI products.
            case (tag_out.idx)
                P_RR:    acc_re_q <= acc_re_q + p_ext;
                P_II:    acc_re_q <= conj_q ? acc_re_q + p_ext : acc_re_q - p_ext;
                P_RI:    acc_im_q <= conj_q ? acc_im_q - p_ext : acc_im_q + p_ext;
                default: acc_im_q <= acc_im_q + p_ext;
            endcase
        end
    end

    assign y_re = acc_re_q;
    assign y_im = acc_im_q;

endmodule

// File: tb/tb_cmul_sequencer.sv
// Directed-vector bench for cmul_sequencer: instance A at MUL_LAT=1, instance B at MUL_LAT=3,
// each paired with a behavioural registered multiplier.
module tb_cmul_sequencer;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic signed [31:0] a_xr, a_xi, a_mul_a;
    logic signed [15:0] a_wr, a_wi, a_mul_b;
    logic signed [48:0] a_y_re, a_y_im;
    logic signed [47:0] a_mul_p;
    logic signed [47:0] a_pp [1];

    logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic signed [31:0] b_xr, b_xi, b_mul_a;
    logic signed [15:0] b_wr, b_wi, b_mul_b;
    logic signed [48:0] b_y_re, b_y_im;
    logic signed [47:0] b_mul_p;
    logic signed [47:0] b_pp [3];

`ifdef CMUL_CONJ_EN
    logic a_conj;
`endif

    cmul_sequencer #(.WIDTH(32), .PROD(48), .MUL_LAT(1)) u_a (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .x_re      (a_xr),
        .x_im      (a_xi),
        .w_re      (a_wr),
        .w_im      (a_wi),
`ifdef CMUL_CONJ_EN
        .conj      (a_conj),
`endif
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .y_re      (a_y_re),
        .y_im      (a_y_im),
        .mul_a     (a_mul_a),
        .mul_b     (a_mul_b),
        .mul_p     (a_mul_p)
    );

    cmul_sequencer #(.WIDTH(32), .PROD(48), .MUL_LAT(3)) u_b (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .x_re      (b_xr),
        .x_im      (b_xi),
        .w_re      (b_wr),
        .w_im      (b_wi),
`ifdef CMUL_CONJ_EN
        .conj      (1'b0),
`endif
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .y_re      (b_y_re),
        .y_im      (b_y_im),
        .mul_a     (b_mul_a),
        .mul_b     (b_mul_b),
        .mul_p     (b_mul_p)
    );

    // Behavioural partial_mul models: full-precision signed product, registered MUL_LAT times.
    always @(posedge clock) a_pp[0] <= a_mul_a * a_mul_b;
    assign a_mul_p = a_pp[0];

    always @(posedge clock) begin
        b_pp[0] <= b_mul_a * b_mul_b;
        b_pp[1] <= b_pp[0];
        b_pp[2] <= b_pp[1];
    end
    assign b_mul_p = b_pp[2];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // Presents one operand set to A from IDLE and waits for out_valid (bounded).
    task automatic do_op_a(input logic signed [31:0] xr, input logic signed [31:0] xi,
                           input logic signed [15:0] wr, input logic signed [15:0] wi,
                           output int lat, output logic signed [48:0] yr, output logic signed [48:0] yi);
        a_xr = xr; a_xi = xi; a_wr = wr; a_wi = wi;
        a_in_valid = 1'b1;
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        yr = a_y_re;
        yi = a_y_im;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", a_in_ready); end
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        n_vec++; if (a_y_re !== 49'sd0 || a_y_im !== 49'sd0) begin n_err++; $display("FAIL reset_y: got (%0d,%0d) expected (0,0)", a_y_re, a_y_im); end
        n_vec++; if (a_mul_a !== 32'sd0 || a_mul_b !== 16'sd0) begin n_err++; $display("FAIL reset_mul: got (%0d,%0d) expected (0,0)", a_mul_a, a_mul_b); end
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b expected 1", a_in_ready); end
    endtask

    task automatic test_basic;
        int lat;
        logic signed [48:0] yr, yi;
        a_out_ready = 1'b1;
        do_op_a(32'sd3, 32'sd4, 16'sd5, -16'sd2, lat, yr, yi);
        n_vec++; if (lat !== 6) begin n_err++; $display("FAIL basic_latency: got %0d expected 6", lat); end
        n_vec++; if (yr !== 49'sd23 || yi !== 49'sd14) begin n_err++; $display("FAIL basic_y: got (%0d,%0d) expected (23,14)", yr, yi); end
        n_vec++; if (a_mul_a !== 32'sd0) begin n_err++; $display("FAIL basic_mul_a_idle: got %0d expected 0", a_mul_a); end
        @(posedge clock); #1;
        n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL basic_handoff: got valid=%b ready=%b expected valid=0 ready=1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_backpressure;
        int lat;
        logic signed [48:0] yr, yi;
        a_out_ready = 1'b0;
        do_op_a(32'sd1, 32'sd1, 16'sd1, 16'sd1, lat, yr, yi);
        n_vec++; if (yr !== 49'sd0 || yi !== 49'sd2) begin n_err++; $display("FAIL bp_y: got (%0d,%0d) expected (0,2)", yr, yi); end
        a_xr = 32'sd99; a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            n_vec++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_flags[%0d]: got valid=%b ready=%b expected valid=1 ready=0", i, a_out_valid, a_in_ready); end
            n_vec++; if (a_y_re !== 49'sd0 || a_y_im !== 49'sd2) begin n_err++; $display("FAIL bp_hold_y[%0d]: got (%0d,%0d) expected (0,2)", i, a_y_re, a_y_im); end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clock); #1;
        n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_extremes;
        int lat;
        logic signed [48:0] yr, yi, exp_im;
        exp_im = 49'sh8000_0000_0000;
        a_out_ready = 1'b1;
        do_op_a(32'sh8000_0000, 32'sh8000_0000, 16'sh8000, 16'sh8000, lat, yr, yi);
        n_vec++; if (yr !== 49'sd0 || yi !== exp_im) begin n_err++; $display("FAIL extremes_y: got (%0d,%0d) expected (0,%0d)", yr, yi, exp_im); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_op;
        int lat;
        logic signed [48:0] yr, yi;
        a_out_ready = 1'b1;
        a_xr = 32'sd10; a_xi = 32'sd20; a_wr = 16'sd30; a_wi = 16'sd40;
        a_in_valid = 1'b1;
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_vec++; if (a_mul_a !== 32'sd10 || a_mul_b !== 16'sd40) begin n_err++; $display("FAIL abort_idx2_operands: got (%0d,%0d) expected (10,40)", a_mul_a, a_mul_b); end
        reset = 1'b0;
        #1;
        n_vec++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_mul_a !== 32'sd0) begin n_err++; $display("FAIL abort_during_reset: got ready=%b valid=%b mul_a=%0d expected 0,0,0", a_in_ready, a_out_valid, a_mul_a); end
        @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        n_vec++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_mul_a !== 32'sd0) begin n_err++; $display("FAIL abort_after_release: got ready=%b valid=%b mul_a=%0d expected 1,0,0", a_in_ready, a_out_valid, a_mul_a); end
        do_op_a(32'sd2, 32'sd0, 16'sd3, 16'sd0, lat, yr, yi);
        n_vec++; if (lat !== 6) begin n_err++; $display("FAIL abort_next_latency: got %0d expected 6", lat); end
        n_vec++; if (yr !== 49'sd6 || yi !== 49'sd0) begin n_err++; $display("FAIL abort_next_y: got (%0d,%0d) expected (6,0)", yr, yi); end
        @(posedge clock); #1;
    endtask

    task automatic test_latency_sweep;
        int lat;
        b_out_ready = 1'b1;
        b_xr = 32'sd7; b_xi = -32'sd1; b_wr = 16'sd2; b_wi = 16'sd3;
        b_in_valid = 1'b1;
        n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL lat3_ready0: got %b expected 1", b_in_ready); end
        @(posedge clock); #1;
        b_xr = -32'sd5; b_xi = 32'sd6; b_wr = 16'sd4; b_wi = -16'sd1;
        lat = 1;
        while (!b_out_valid && lat < 40) begin @(posedge clock); #1; lat++; end
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL lat3_op1_latency: got %0d expected 8", lat); end
        n_vec++; if (b_y_re !== 49'sd17 || b_y_im !== 49'sd19) begin n_err++; $display("FAIL lat3_op1_y: got (%0d,%0d) expected (17,19)", b_y_re, b_y_im); end
        @(posedge clock); #1;
        n_vec++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin n_err++; $display("FAIL lat3_idle: got ready=%b valid=%b expected 1,0", b_in_ready, b_out_valid); end
        @(posedge clock); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 40) begin @(posedge clock); #1; lat++; end
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL lat3_op2_latency: got %0d expected 8", lat); end
        n_vec++; if (b_y_re !== -49'sd14 || b_y_im !== 49'sd29) begin n_err++; $display("FAIL lat3_op2_y: got (%0d,%0d) expected (-14,29)", b_y_re, b_y_im); end
        @(posedge clock); #1;
        n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL lat3_done_release: got %b expected 0", b_out_valid); end
    endtask

    task automatic test_conj;
`ifdef CMUL_CONJ_EN
        int lat;
        logic signed [48:0] yr, yi;
        a_out_ready = 1'b1;
        a_conj = 1'b1;
        do_op_a(32'sd3, 32'sd4, 16'sd5, -16'sd2, lat, yr, yi);
        a_conj = 1'b0;
        n_vec++; if (yr !== 49'sd7 || yi !== 49'sd26) begin n_err++; $display("FAIL conj_y: got (%0d,%0d) expected (7,26)", yr, yi); end
        @(posedge clock); #1;
        do_op_a(32'sd3, 32'sd4, 16'sd5, -16'sd2, lat, yr, yi);
        n_vec++; if (yr !== 49'sd23 || yi !== 49'sd14) begin n_err++; $display("FAIL conj_off_y: got (%0d,%0d) expected (23,14)", yr, yi); end
        @(posedge clock); #1;
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        a_xr = '0; a_xi = '0; a_wr = '0; a_wi = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_xr = '0; b_xi = '0; b_wr = '0; b_wi = '0;
`ifdef CMUL_CONJ_EN
        a_conj = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_extremes();
        test_reset_mid_op();
        test_latency_sweep();
        test_conj();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
